mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Iterative RV32M multiply/divide execution unit. It sits directly downstream of the register file and consumes its two read ports (registerRead1/registerRead2) as operands. It feeds its result back to the register file write port (dataToWrite/writeRegister/rd). It runs one operation at a time with fixed latency, and the core stalls on busy.

Parameters:
WIDTH, 32, operand/result width. Latency in cycles is WIDTH+2.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only when busy=0
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operandA  input  WIDTH  rs1 value (registerRead1)
operandB  input  WIDTH  rs2 value (registerRead2)
rdIn  input  5  destination register
flush  input  1  cancel the in-flight operation (branch/trap)
busy  output  1  operation in flight; start ignored
done  output  1  one-cycle pulse; result valid
result  output  WIDTH  result to dataToWrite
rd  output  5  destination register for the writeback
writeRegister  output  1  write strobe = done && rd!=0

Behaviour:
- Reset (async, any state): state IDLE; busy, done, writeRegister=0; result=0; rd=0; internal accumulators cleared.
- States: IDLE -> CALC (WIDTH cycles) -> FIX (1) -> DONE (1) -> IDLE.
- Timing: start=1 in cycle 0 with busy=0 latches funct3, operands and rdIn at the cycle-0 edge.
  - busy=1 in cycles 1..WIDTH+2.
  - done=1 only in cycle WIDTH+2 (cycle 34 for WIDTH=32).
  - busy=0 from cycle WIDTH+3; a new start may be accepted in that cycle.
- start while busy=1: ignored; latched operands are unchanged.
- Operand handling:
  - Signed ops take absolute values at latch; the result sign is recorded: MULH = a^b, MULHSU = a, DIV = a^b, REM = a (dividend).
  - MULHU/MULHSU treat unsigned operands as-is.
- CALC, multiply: shift-add over a 2*WIDTH product, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle. The remainder register is WIDTH+1 bits to hold the subtract borrow.
- FIX:
  - Conditionally two's-complement-negate the product or the quotient/remainder.
  - Select the low word for MUL and the high word for MULH/MULHSU/MULHU.
  - Register the selected value into result.
- Special cases still take the full latency (no early exit):
  - Divide by zero: DIV/DIVU -> all ones (0xFFFFFFFF); REM/REMU -> operandA.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- result and rd hold their values after done until the next DONE or reset.
- writeRegister pulses only with done and only when rd!=0.
- flush=1 while busy: go to IDLE next edge. busy falls next cycle, with no done and no writeRegister. flush in IDLE has no effect. flush in the DONE cycle does not suppress that cycle's done.
- start and flush in the same cycle while IDLE: start is accepted.
- All arithmetic is modulo 2^WIDTH except the internal 2*WIDTH product. There are no X or overflow flags.

Test Plan:
- Reset mid-operation: assert reset in cycle 10 of a DIV -> busy=0, done=0, result=0 immediately (async); no writeRegister follows.
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD), rd=5 -> done in cycle 34; result=0xFFFFFFEB; writeRegister=1; rd=5. Same with MULH -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- Divide by zero: DIV 0x12345678/0 -> 0xFFFFFFFF; REM -> 0x12345678. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. All with done in cycle 34.
- Handshake:
  - start re-pulsed in cycle 5 with different operands -> ignored; the original result is delivered.
  - flush in cycle 20 -> busy=0 in cycle 21; no done.
  - Back-to-back start in cycle 35 is accepted.
- rdIn=0 with MUL 3x4 -> done=1, result=12, writeRegister=0.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the register file and the RV32M multiply/divide unit.
`timescale 1ns/1ps
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic [4:0]       rdIn;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [4:0]       rd;
  logic             writeRegister;

  modport master (
    output start, funct3, operandA, operandB, rdIn, flush,
    input  busy, done, result, rd, writeRegister
  );

  modport slave (
    input  start, funct3, operandA, operandB, rdIn, flush,
    output busy, done, result, rd, writeRegister
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// fixed WIDTH+2 cycle latency, result handed to the register-file write port.
`timescale 1ns/1ps
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clock,
  input logic           reset,
  mul_div_unit_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic [2:0]         op;
  logic               neg;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;
  logic [CW-1:0]      cnt;
  logic [4:0]         rd_lat;

  logic             busy_q;
  logic             done_q;
  logic             wr_q;
  logic [WIDTH-1:0] result_q;
  logic [4:0]       rd_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] lat_a, lat_b;
  logic             lat_neg;

  // Operand conditioning at latch time: magnitude for signed operands plus result sign
  always_comb begin
    a_neg   = bus.operandA[WIDTH-1];
    b_neg   = bus.operandB[WIDTH-1];
    a_abs   = a_neg ? WIDTH'(0) - bus.operandA : bus.operandA;
    b_abs   = b_neg ? WIDTH'(0) - bus.operandB : bus.operandB;
    lat_a   = bus.operandA;
    lat_b   = bus.operandB;
    lat_neg = 1'b0;
    case (bus.funct3)
      3'b001: begin
        lat_a   = a_abs;
        lat_b   = b_abs;
        lat_neg = a_neg ^ b_neg;
      end
      3'b010: begin
        lat_a   = a_abs;
        lat_neg = a_neg;
      end
      3'b100: begin
        // A zero divisor must yield all ones regardless of dividend sign
        lat_a   = a_abs;
        lat_b   = b_abs;
        lat_neg = (a_neg ^ b_neg) && (bus.operandB != '0);
      end
      3'b110: begin
        lat_a   = a_abs;
        lat_b   = b_abs;
        lat_neg = a_neg;
      end
      default: ;
    endcase
  end

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_trial;

  // One iteration step of each datapath
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : (WIDTH+1)'(0));
    div_shift = (WIDTH+1)'({rem, quo[WIDTH-1]});
    div_trial = div_shift - {1'b0, mcand};
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_sel;

  // Sign correction and word selection for the final result
  always_comb begin
    prod_fix = neg ? (2*WIDTH)'(0) - prod : prod;
    quo_fix  = neg ? WIDTH'(0) - quo : quo;
    rem_fix  = neg ? WIDTH'(0) - rem[WIDTH-1:0] : rem[WIDTH-1:0];
    case (op)
      3'b000:                 fix_sel = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_sel = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_sel = quo_fix;
      default:                fix_sel = rem_fix;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op       <= '0;
      neg      <= 1'b0;
      mcand    <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      rd_lat   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_q     <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          wr_q   <= 1'b0;
          if (bus.start) begin
            op     <= bus.funct3;
            neg    <= lat_neg;
            mcand  <= bus.funct3[2] ? lat_b : lat_a;
            prod   <= {WIDTH'(0), lat_b};
            quo    <= lat_a;
            rem    <= '0;
            rd_lat <= bus.rdIn;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            if (op[2]) begin
              rem <= div_trial[WIDTH] ? div_shift : div_trial;
              quo <= {quo[WIDTH-2:0], ~div_trial[WIDTH]};
            end else begin
              prod <= {mul_sum, prod[WIDTH-1:1]};
            end
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            result_q <= fix_sel;
            rd_q     <= rd_lat;
            done_q   <= 1'b1;
            wr_q     <= (rd_lat != 5'd0);
            state    <= DONE;
          end
        end
        default: begin
          done_q <= 1'b0;
          wr_q   <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.writeRegister = wr_q;
  assign bus.result        = result_q;
  assign bus.rd            = rd_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic vectors, special cases, handshake and reset.
`timescale 1ns/1ps
module tb_mul_div_unit;
  logic clock;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rdi;
    logic [31:0] exp;
  } vec_t;

  // Issue one op at cycle 0 (caller is just after a rising edge); watches up to
  // 40 cycles and returns just after the rising edge that follows done.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rdi, input int restart_cyc, input int flush_cyc,
                        output int done_cyc, output logic [31:0] res, output logic wr,
                        output logic [4:0] rdo, output logic busy_ok,
                        output logic busy_after_flush, output logic wr_stray);
    int cyc;
    done_cyc = -1; res = '0; wr = 1'b0; rdo = '0;
    busy_ok = 1'b1; busy_after_flush = 1'b1; wr_stray = 1'b0;
    bus.start = 1'b1; bus.funct3 = f3; bus.operandA = a; bus.operandB = b; bus.rdIn = rdi;
    bus.flush = (flush_cyc == 0);
    @(posedge clock); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    cyc = 1;
    while (cyc <= 40 && done_cyc < 0) begin
      bus.start = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        bus.funct3 = 3'b000; bus.operandA = 32'd1000; bus.operandB = 32'd3; bus.rdIn = 5'd1;
      end
      bus.flush = (cyc == flush_cyc);
      @(negedge clock);
      if (bus.done) begin
        done_cyc = cyc; res = bus.result; wr = bus.writeRegister; rdo = bus.rd;
      end else if (bus.writeRegister) begin
        wr_stray = 1'b1;
      end
      if (flush_cyc <= 0 && cyc <= 34 && bus.busy !== 1'b1) busy_ok = 1'b0;
      if (cyc == flush_cyc + 1) busy_after_flush = bus.busy;
      @(posedge clock); #1;
      cyc++;
    end
    bus.start = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.writeRegister !== 1'b0) $display("FAIL reset_wr: got %b expected 0", bus.writeRegister); else pass_cnt++;
    total_cnt++; if (bus.result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", bus.result); else pass_cnt++;
    total_cnt++; if (bus.rd !== 5'd0) $display("FAIL reset_rd: got %0d expected 0", bus.rd); else pass_cnt++;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_mul();
    vec_t v[4];
    int dc; logic [31:0] r; logic w; logic [4:0] ro; logic bo, baf, ws;
    v[0] = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB};
    v[1] = '{3'b001, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFFF};
    v[2] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE};
    v[3] = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      run_op(v[i].f3, v[i].a, v[i].b, v[i].rdi, -1, -1, dc, r, w, ro, bo, baf, ws);
      total_cnt++; if (dc !== 34) $display("FAIL mul[%0d]_done_cycle: got %0d expected 34", i, dc); else pass_cnt++;
      total_cnt++; if (r !== v[i].exp) $display("FAIL mul[%0d]_result: got %h expected %h", i, r, v[i].exp); else pass_cnt++;
      total_cnt++; if (w !== 1'b1) $display("FAIL mul[%0d]_wr: got %b expected 1", i, w); else pass_cnt++;
      total_cnt++; if (ro !== v[i].rdi) $display("FAIL mul[%0d]_rd: got %0d expected %0d", i, ro, v[i].rdi); else pass_cnt++;
      total_cnt++; if (bo !== 1'b1) $display("FAIL mul[%0d]_busy: got %b expected 1", i, bo); else pass_cnt++;
    end
    // After done: strobes drop, result and rd hold
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL mul_done_after: got %b expected 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.writeRegister !== 1'b0) $display("FAIL mul_wr_after: got %b expected 0", bus.writeRegister); else pass_cnt++;
    total_cnt++; if (bus.result !== 32'hFFFFFFFF) $display("FAIL mul_result_hold: got %h expected ffffffff", bus.result); else pass_cnt++;
    total_cnt++; if (bus.rd !== 5'd31) $display("FAIL mul_rd_hold: got %0d expected 31", bus.rd); else pass_cnt++;
  endtask

  task automatic test_div();
    vec_t v[9];
    int dc; logic [31:0] r; logic w; logic [4:0] ro; logic bo, baf, ws;
    v[0] = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 5'd10, 32'hFFFFFFFD};
    v[1] = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 5'd11, 32'hFFFFFFFF};
    v[2] = '{3'b101, 32'd100,      32'd7,        5'd12, 32'd14};
    v[3] = '{3'b111, 32'd100,      32'd7,        5'd13, 32'd2};
    v[4] = '{3'b100, 32'h12345678, 32'h00000000, 5'd14, 32'hFFFFFFFF};
    v[5] = '{3'b110, 32'h12345678, 32'h00000000, 5'd15, 32'h12345678};
    v[6] = '{3'b100, 32'hFFFFFFF8, 32'h00000000, 5'd16, 32'hFFFFFFFF};
    v[7] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000};
    v[8] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h00000000};
    for (int i = 0; i < 9; i++) begin
      run_op(v[i].f3, v[i].a, v[i].b, v[i].rdi, -1, -1, dc, r, w, ro, bo, baf, ws);
      total_cnt++; if (dc !== 34) $display("FAIL div[%0d]_done_cycle: got %0d expected 34", i, dc); else pass_cnt++;
      total_cnt++; if (r !== v[i].exp) $display("FAIL div[%0d]_result: got %h expected %h", i, r, v[i].exp); else pass_cnt++;
      total_cnt++; if (ro !== v[i].rdi) $display("FAIL div[%0d]_rd: got %0d expected %0d", i, ro, v[i].rdi); else pass_cnt++;
    end
  endtask

  task automatic test_handshake();
    int dc; logic [31:0] r; logic w; logic [4:0] ro; logic bo, baf, ws;
    // Re-pulsed start mid-operation must not disturb the latched op
    run_op(3'b101, 32'd100, 32'd7, 5'd3, 5, -1, dc, r, w, ro, bo, baf, ws);
    total_cnt++; if (dc !== 34) $display("FAIL restart_done_cycle: got %0d expected 34", dc); else pass_cnt++;
    total_cnt++; if (r !== 32'd14) $display("FAIL restart_result: got %h expected 0000000e", r); else pass_cnt++;
    total_cnt++; if (ro !== 5'd3) $display("FAIL restart_rd: got %0d expected 3", ro); else pass_cnt++;
    // Flush in cycle 20
    run_op(3'b000, 32'd3, 32'd4, 5'd7, -1, 20, dc, r, w, ro, bo, baf, ws);
    total_cnt++; if (baf !== 1'b0) $display("FAIL flush_busy: got %b expected 0", baf); else pass_cnt++;
    total_cnt++; if (dc !== -1) $display("FAIL flush_no_done: got done in cycle %0d expected none", dc); else pass_cnt++;
    total_cnt++; if (ws !== 1'b0) $display("FAIL flush_no_wr: got %b expected 0", ws); else pass_cnt++;
    // Start and flush together in idle: start wins
    run_op(3'b011, 32'd5, 32'd6, 5'd8, -1, 0, dc, r, w, ro, bo, baf, ws);
    total_cnt++; if (dc !== 34) $display("FAIL start_flush_done_cycle: got %0d expected 34", dc); else pass_cnt++;
    total_cnt++; if (r !== 32'd0) $display("FAIL start_flush_result: got %h expected 00000000", r); else pass_cnt++;
    total_cnt++; if (w !== 1'b1) $display("FAIL start_flush_wr: got %b expected 1", w); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int dc; logic [31:0] r; logic w; logic [4:0] ro; logic bo, baf, ws;
    run_op(3'b000, 32'd3, 32'd4, 5'd0, -1, -1, dc, r, w, ro, bo, baf, ws);
    total_cnt++; if (dc !== 34) $display("FAIL rd0_done_cycle: got %0d expected 34", dc); else pass_cnt++;
    total_cnt++; if (r !== 32'd12) $display("FAIL rd0_result: got %h expected 0000000c", r); else pass_cnt++;
    total_cnt++; if (w !== 1'b0) $display("FAIL rd0_wr: got %b expected 0", w); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL b2b_busy_cycle35: got %b expected 0", bus.busy); else pass_cnt++;
    // Start issued in cycle 35 of the previous op
    run_op(3'b101, 32'd100, 32'd7, 5'd9, -1, -1, dc, r, w, ro, bo, baf, ws);
    total_cnt++; if (dc !== 34) $display("FAIL b2b_done_cycle: got %0d expected 34", dc); else pass_cnt++;
    total_cnt++; if (r !== 32'd14) $display("FAIL b2b_result: got %h expected 0000000e", r); else pass_cnt++;
    total_cnt++; if (w !== 1'b1) $display("FAIL b2b_wr: got %b expected 1", w); else pass_cnt++;
    total_cnt++; if (ro !== 5'd9) $display("FAIL b2b_rd: got %0d expected 9", ro); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int done_seen;
    int wr_seen;
    done_seen = 0; wr_seen = 0;
    bus.start = 1'b1; bus.funct3 = 3'b100; bus.operandA = 32'hFFFFFFF9; bus.operandB = 32'd2; bus.rdIn = 5'd4;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL rstmid_done: got %b expected 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.result !== 32'h0) $display("FAIL rstmid_result: got %h expected 00000000", bus.result); else pass_cnt++;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (bus.done) done_seen++;
      if (bus.writeRegister) wr_seen++;
    end
    total_cnt++; if (done_seen !== 0) $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_seen); else pass_cnt++;
    total_cnt++; if (wr_seen !== 0) $display("FAIL rstmid_no_wr: got %0d pulses expected 0", wr_seen); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.funct3 = '0; bus.operandA = '0; bus.operandB = '0;
    bus.rdIn = '0; bus.flush = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, %0d/%0d so far", pass_cnt, total_cnt);
    $fatal(1);
  end
endmodule
